// File: rtl/varint_encoder_fsm_if.sv
// varint_encoder_fsm_if
//   Bundles the field-input handshake and the varint FIFO-pair write port
//   of the varint encoder into one interface.
//
//   Field input : in_valid, in_ready, in_value[63:0], in_index[9:0], in_zigzag
//   FIFO side   : fifo_full, fifo_clr, fifo_push, fifo_data[7:0], fifo_index[9:0]
//   Status      : enc_done (pulse on a field's final byte), enc_len[3:0]
//
//   Modports:
//     slave  - the encoder itself (accepts fields, drives the FIFO write port)
//     master - the environment (offers fields, reports FIFO full, sees pushes)
interface varint_encoder_fsm_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_value;
  logic [9:0]  in_index;
  logic        in_zigzag;
  logic        fifo_full;
  logic        fifo_clr;
  logic        fifo_push;
  logic [7:0]  fifo_data;
  logic [9:0]  fifo_index;
  logic        enc_done;
  logic [3:0]  enc_len;

  modport slave (
    input  in_valid, in_value, in_index, in_zigzag, fifo_full,
    output in_ready, fifo_clr, fifo_push, fifo_data, fifo_index, enc_done, enc_len
  );

  modport master (
    output in_valid, in_value, in_index, in_zigzag, fifo_full,
    input  in_ready, fifo_clr, fifo_push, fifo_data, fifo_index, enc_done, enc_len
  );
endinterface

// File: rtl/varint_encoder_fsm.sv
// varint_encoder_fsm
//   Encodes one 64-bit field value (optionally zig-zag mapped) as a protobuf
//   base-128 varint and writes it one byte per cycle into the varint
//   data/index FIFO pair. Every byte carries the field's 10-bit index tag.
//
//   Ports:
//     clk   - clock, rising edge
//     reset - synchronous, active-high
//     bus   - varint_encoder_fsm_if.slave: field handshake, FIFO write port,
//             enc_done/enc_len completion status
module varint_encoder_fsm (
  input  logic clk,
  input  logic reset,
  varint_encoder_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    INIT = 3'b001,
    IDLE = 3'b010,
    EMIT = 3'b100
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] shreg_q, shreg_d;
  logic [9:0]  index_q, index_d;
  logic [3:0]  count_q, count_d;

  logic        more;
  logic [63:0] load_value;

  // A continuation bit is needed whenever anything remains above the low 7 bits.
  assign more = |shreg_q[63:7];

  // Zig-zag maps signed values so small magnitudes give short encodings.
  assign load_value = bus.in_zigzag ?
                      ((bus.in_value << 1) ^ {64{bus.in_value[63]}}) :
                      bus.in_value;

  // Next-state and output decode. Handshake/push outputs are forced low while
  // reset is held so a byte presented in the reset cycle is never written.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    index_d        = index_q;
    count_d        = count_q;
    bus.in_ready   = 1'b0;
    bus.fifo_clr   = 1'b0;
    bus.fifo_push  = 1'b0;
    bus.enc_done   = 1'b0;
    bus.enc_len    = 4'd0;
    // Data/index are driven continuously so they stay stable within a cycle.
    bus.fifo_data  = {more, shreg_q[6:0]};
    bus.fifo_index = index_q;

    case (state_q)
      INIT: begin
        bus.fifo_clr = 1'b1;
        count_d      = 4'd0;
        state_d      = IDLE;
      end

      IDLE: begin
        bus.in_ready = ~reset;
        if (bus.in_valid) begin
          shreg_d = load_value;
          index_d = bus.in_index;
          count_d = 4'd0;
          state_d = EMIT;
        end
      end

      EMIT: begin
        // A full FIFO holds everything in place; the pending byte is unchanged.
        if (!bus.fifo_full) begin
          bus.fifo_push = ~reset;
          shreg_d       = shreg_q >> 7;
          count_d       = count_q + 4'd1;
          if (!more) begin
            bus.enc_done = ~reset;
            bus.enc_len  = reset ? 4'd0 : (count_q + 4'd1);
            state_d      = IDLE;
          end
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  // State registers; reset discards any partially emitted field.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      shreg_q <= 64'd0;
      index_q <= 10'd0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      index_q <= index_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_varint_encoder_fsm.sv
// tb_varint_encoder_fsm
//   Self-checking bench for varint_encoder_fsm. Each issued field pushes its
//   hand-computed byte sequence into a scoreboard queue; a monitor pops and
//   compares on every FIFO push.
module tb_varint_encoder_fsm;

  logic clk;
  logic reset;

  varint_encoder_fsm_if bus ();

  varint_encoder_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] index;
    logic       last;
    logic [3:0] len;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks     = 0;
  int   errors     = 0;
  int   push_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Queues the expected bytes, then offers the field and returns at the
  // negedge of the first push cycle (cycle after acceptance).
  task automatic applyStimulus(input logic [63:0] value, input logic [9:0] index,
                               input logic zz, input logic [79:0] bytes_in, input int n);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    end
    for (int i = 0; i < n; i++) begin
      e.data  = bytes_in[8*i +: 8];
      e.index = index;
      e.last  = (i == n - 1);
      e.len   = 4'(n);
      exp_q.push_back(e);
    end
    bus.in_valid  = 1'b1;
    bus.in_value  = value;
    bus.in_index  = index;
    bus.in_zigzag = zz;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  // Waits (bounded) until every expected byte has been seen and the block is idle.
  task automatic waitIdle(input string name);
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0 || !bus.in_ready) begin
      checkOutput({name, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor, sampling mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (bus.fifo_push === 1'b1) begin
      push_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_push", 64'(bus.fifo_data), 64'hDEAD);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("fifo_data", 64'(bus.fifo_data), 64'(mon_e.data));
        checkOutput("fifo_index", 64'(bus.fifo_index), 64'(mon_e.index));
        checkOutput("enc_done", 64'(bus.enc_done), 64'(mon_e.last));
        if (mon_e.last) begin
          checkOutput("enc_len", 64'(bus.enc_len), 64'(mon_e.len));
        end
      end
    end else if (bus.enc_done === 1'b1) begin
      checkOutput("done_without_push", 64'(bus.enc_done), 64'd0);
    end
  end

  initial begin
    int saved_pushes;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_value  = 64'd0;
    bus.in_index  = 10'd0;
    bus.in_zigzag = 1'b0;
    bus.fifo_full = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("rst_fifo_push", 64'(bus.fifo_push), 64'd0);
    checkOutput("rst_enc_done", 64'(bus.enc_done), 64'd0);
    checkOutput("rst_enc_len", 64'(bus.enc_len), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("init_fifo_clr", 64'(bus.fifo_clr), 64'd1);
    checkOutput("init_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    checkOutput("idle_fifo_clr", 64'(bus.fifo_clr), 64'd0);
    checkOutput("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Value 0: single 0x00 byte, in_ready back two cycles after accept.
    $display("[TB] value 0");
    applyStimulus(64'd0, 10'd5, 1'b0, 80'h00, 1);
    checkOutput("v0_push_n1", 64'(bus.fifo_push), 64'd1);
    checkOutput("v0_ready_n1", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    checkOutput("v0_ready_n2", 64'(bus.in_ready), 64'd1);
    waitIdle("v0");

    $display("[TB] directed vectors");
    applyStimulus(64'd300, 10'd7, 1'b0, 80'h02AC, 2);
    waitIdle("v300");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 10'd3, 1'b0, 80'h01_FFFF_FFFF_FFFF_FFFF_FF, 10);
    waitIdle("vmax");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 10'd9, 1'b1, 80'h01, 1);
    waitIdle("zz_m1");
    applyStimulus(64'h8000_0000_0000_0000, 10'h3FF, 1'b1, 80'h01_FFFF_FFFF_FFFF_FFFF_FF, 10);
    waitIdle("zz_min");
    applyStimulus(64'd1, 10'd100, 1'b1, 80'h02, 1);
    waitIdle("zz_p1");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFE, 10'd101, 1'b1, 80'h03, 1);
    waitIdle("zz_m2");
    applyStimulus(64'd127, 10'd200, 1'b0, 80'h7F, 1);
    waitIdle("v127");
    applyStimulus(64'd128, 10'd201, 1'b0, 80'h0180, 2);
    waitIdle("v128");
    applyStimulus(64'd16384, 10'd202, 1'b0, 80'h01_8080, 3);
    waitIdle("v16384");

    // Stall: FIFO full for three cycles right after the first byte is written.
    $display("[TB] stall");
    applyStimulus(64'd300, 10'd7, 1'b0, 80'h02AC, 2);
    @(posedge clk);
    #1 bus.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_no_push", 64'(bus.fifo_push), 64'd0);
      checkOutput("stall_data_held", 64'(bus.fifo_data), 64'h02);
      @(posedge clk);
    end
    #1 bus.fifo_full = 1'b0;
    @(negedge clk);
    checkOutput("stall_resume_push", 64'(bus.fifo_push), 64'd1);
    checkOutput("stall_resume_done", 64'(bus.enc_done), 64'd1);
    waitIdle("stall");

    // Reset after the second of ten bytes has been written.
    $display("[TB] reset mid-field");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 10'd4, 1'b0, 80'h01_FFFF_FFFF_FFFF_FFFF_FF, 10);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    saved_pushes = push_count;
    @(negedge clk);
    checkOutput("midrst_push", 64'(bus.fifo_push), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrst_fifo_clr", 64'(bus.fifo_clr), 64'd1);
    repeat (4) @(negedge clk);
    checkOutput("midrst_no_pushes", 64'(push_count - saved_pushes), 64'd0);
    checkOutput("midrst_ready", 64'(bus.in_ready), 64'd1);
    applyStimulus(64'd300, 10'd1, 1'b0, 80'h02AC, 2);
    waitIdle("post_rst");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
